// File: rtl/switch_pkg.sv
// Shared constants and arbiter state encoding for the 4x4 switch.
package switch_pkg;
    localparam int NQ      = 4;
    localparam int DEPTH   = 128;
    localparam int DW      = 32;
    localparam int EOP_BIT = DW;
    localparam int QW      = DW + 1;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } arb_state_e;
endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set bit of mask at or above ptr, wrapping mod 4.
module rr_select (
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any_set
);
    logic [1:0] cand;

    always_comb begin
        idx     = '0;
        cand    = '0;
        any_set = |mask;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (mask[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// Packet-granular round-robin drain of four queues onto one valid/ready output port.
// Define ARB_STATS_EN to add per-queue packet counters (pkt_cnt) and sticky overflow flags (ovf).
module output_port_arbiter
    import switch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NQ-1:0]      q_push,
    input  logic [NQ*QW-1:0]   q_rd_data,
    output logic [NQ-1:0]      q_rd_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic               out_last,
    output logic [1:0]         grant,
    output logic               busy
`ifdef ARB_STATS_EN
    ,
    output logic [NQ*STAT_W-1:0] pkt_cnt,
    output logic [NQ-1:0]        ovf
`endif
);
    // Output handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; out_data/out_last hold steady while out_valid waits.
    arb_state_e       state;
    logic [OCC_W-1:0] occ [NQ];
    logic [NQ-1:0]    nonempty;
    logic [1:0]       ptr;
    logic [1:0]       next_idx;
    logic             any_ne;
    logic [QW-1:0]    cur_word;
    logic             accept;

    always_comb begin
        nonempty = '0;
        for (int k = 0; k < NQ; k++) nonempty[k] = (occ[k] != '0);
    end

    rr_select u_rr_select (
        .mask    (nonempty),
        .ptr     (ptr),
        .idx     (next_idx),
        .any_set (any_ne)
    );

    assign cur_word = q_rd_data[grant*QW +: QW];
    assign accept   = (state == HOLD) && out_ready;
    assign busy     = (state != IDLE);

    // A pop is only issued against a known-present word, so the queue never underflows.
    always_comb begin
        q_rd_en = '0;
        if (state == REQ && nonempty[grant]) q_rd_en[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NQ; k++) occ[k] <= '0;
        end else begin
            for (int k = 0; k < NQ; k++) begin
                case ({q_push[k], q_rd_en[k]})
                    2'b10:   if (occ[k] != OCC_W'(DEPTH)) occ[k] <= occ[k] + OCC_W'(1);
                    2'b01:   occ[k] <= occ[k] - OCC_W'(1);
                    default: occ[k] <= occ[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_ne) begin
                        grant <= next_idx;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (nonempty[grant]) state <= WAIT;
                end
                WAIT: begin
                    out_data  <= cur_word[DW-1:0];
                    out_last  <= cur_word[EOP_BIT];
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= IDLE;
                            ptr   <= grant + 2'd1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt <= '0;
            ovf     <= '0;
        end else begin
            if (accept && out_last)
                pkt_cnt[grant*STAT_W +: STAT_W] <= pkt_cnt[grant*STAT_W +: STAT_W] + 16'd1;
            for (int k = 0; k < NQ; k++)
                if (q_push[k] && occ[k] == OCC_W'(DEPTH)) ovf[k] <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: queue models, round-robin packet-order model, scoreboard.
module tb_output_port_arbiter;
    import switch_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NQ-1:0]     q_push = '0;
    logic [NQ*QW-1:0]  q_rd_data = '0;
    logic [NQ-1:0]     q_rd_en;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [1:0]        grant;
    logic              busy;
`ifdef ARB_STATS_EN
    logic [NQ*STAT_W-1:0] pkt_cnt;
    logic [NQ-1:0]        ovf;
`endif

    output_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .q_push    (q_push),
        .q_rd_data (q_rd_data),
        .q_rd_en   (q_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .grant     (grant),
        .busy      (busy)
`ifdef ARB_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .ovf       (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [QW-1:0]   qm  [NQ][$];
    logic [QW-1:0]   lw  [NQ][$];
    logic [QW-1:0]   tmp [NQ][$];
    logic [QW+1:0]   exp_q[$];
    int              mptr = 0;
    int              pop_cyc[$];
    logic [NQ-1:0]   pop_en[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue models: registered read data, one word per pop strobe.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < NQ; k++)
            if (q_rd_en[k] && qm[k].size() > 0) q_rd_data[k*QW +: QW] <= qm[k].pop_front();
    end

    // Monitor / scoreboard on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (q_rd_en != '0) begin
                check("rd_en_onehot", 64'($onehot(q_rd_en)), 64'd1);
                for (int k = 0; k < NQ; k++)
                    if (q_rd_en[k]) check("pop_nonempty", 64'(qm[k].size() != 0), 64'd1);
                pop_cyc.push_back(cyc);
                pop_en.push_back(q_rd_en);
            end
            if (out_valid && out_ready) begin
                check("word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("out_word", 64'({grant, out_last, out_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic plan_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) lw[k].push_back({(i == len - 1), DW'($urandom())});
    endtask

    // Round-robin reference: whole packets, first non-empty queue from the pointer.
    task automatic model_order();
        int sel;
        bit found;
        logic [QW-1:0] w;
        for (int k = 0; k < NQ; k++) tmp[k] = lw[k];
        while (1) begin
            found = 0;
            sel = 0;
            for (int i = 0; i < NQ; i++)
                if (!found && tmp[(mptr + i) % NQ].size() > 0) begin
                    found = 1;
                    sel = (mptr + i) % NQ;
                end
            if (!found) break;
            w = '0;
            while (tmp[sel].size() > 0 && !w[EOP_BIT]) begin
                w = tmp[sel].pop_front();
                exp_q.push_back({2'(sel), w});
            end
            mptr = (sel + 1) % NQ;
        end
    endtask

    task automatic push_all();
        bit more;
        more = 1;
        while (more) begin
            more = 0;
            for (int k = 0; k < NQ; k++)
                if (lw[k].size() > 0) begin
                    q_push[k] = 1'b1;
                    qm[k].push_back(lw[k].pop_front());
                    more = 1;
                end
            if (more) begin
                @(posedge clk);
                #1 q_push = '0;
            end
        end
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        check("drain_in_budget", 64'(n < budget), 64'd1);
        out_ready = 1'b1;
        check("queues_drained",
              64'(qm[0].size() + qm[1].size() + qm[2].size() + qm[3].size()), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n < 50), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        for (int k = 0; k < NQ; k++) begin
            qm[k].delete();
            lw[k].delete();
        end
        mptr = 0;
        q_push = '0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random steps ----------------
    initial begin
        logic [DW-1:0] held;
        logic [QW-1:0] w;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_q_rd_en", 64'(q_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        rst = 1'b1;

        // Single 3-word packet on queue 2, ready held high.
        pop_cyc.delete();
        pop_en.delete();
        plan_pkt(2, 3);
        model_order();
        push_all();
        drain(0, 200);
        check("single_pop_count", 64'(pop_cyc.size()), 64'd3);
        if (pop_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) check("single_pop_en", 64'(pop_en[i]), 64'b0100);
            check("single_pop_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd3);
            check("single_pop_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd3);
        end

        // Pointer now 3: queue 3 beats queue 0.
        plan_pkt(0, 1);
        plan_pkt(3, 1);
        model_order();
        push_all();
        drain(0, 200);

        // Round-robin from pointer 0 across all four queues, then pointer back at 0.
        do_reset();
        for (int k = 0; k < NQ; k++) plan_pkt(k, 1);
        model_order();
        push_all();
        drain(0, 200);
        plan_pkt(1, 1);
        plan_pkt(0, 1);
        model_order();
        push_all();
        drain(0, 200);

        // Backpressure in HOLD.
        out_ready = 1'b0;
        plan_pkt(1, 2);
        model_order();
        push_all();
        wait_valid("bp_valid_seen");
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data_stable", 64'(out_data), 64'(held));
            check("bp_no_pop", 64'(q_rd_en), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_resume_pop", 64'(q_rd_en), 64'b0010);
        drain(0, 200);

        // Starved mid-packet on queue 1.
        w = {1'b0, DW'($urandom())};
        exp_q.push_back({2'd1, w});
        lw[1].push_back(w);
        push_all();
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("starve_no_pop", 64'(q_rd_en), 64'd0);
            check("starve_busy", 64'(busy), 64'd1);
        end
        w = {1'b1, DW'($urandom())};
        exp_q.push_back({2'd1, w});
        lw[1].push_back(w);
        push_all();
        drain(0, 200);
        mptr = 2;

        // Random batches with random backpressure.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < NQ; k++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) plan_pkt(k, $urandom_range(1, 6));
            end
            model_order();
            out_ready = 1'b0;
            push_all();
            drain(1, 3000);
        end

        // Asynchronous reset while in HOLD.
        out_ready = 1'b0;
        plan_pkt(0, 1);
        model_order();
        push_all();
        wait_valid("hold_reached");
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_last", 64'(out_last), 64'd0);
        check("arst_q_rd_en", 64'(q_rd_en), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_grant", 64'(grant), 64'd0);
        exp_q.delete();
        for (int k = 0; k < NQ; k++) qm[k].delete();
        mptr = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(busy), 64'd0);
        plan_pkt(2, 1);
        plan_pkt(0, 2);
        model_order();
        push_all();
        drain(0, 300);

`ifdef ARB_STATS_EN
        do_reset();
        check("stats_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("stats_rst_ovf", 64'(ovf), 64'd0);
        plan_pkt(3, 1);
        plan_pkt(3, 2);
        model_order();
        push_all();
        drain(0, 300);
        check("stats_pkt_cnt", 64'(pkt_cnt), {16'd2, 48'd0});
        out_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            q_push = 4'b0001;
            if (qm[0].size() < DEPTH) qm[0].push_back({1'b0, DW'(i)});
            @(posedge clk);
            #1;
        end
        q_push = '0;
        @(posedge clk);
        #1;
        check("stats_ovf", 64'(ovf), 64'b0001);
        out_ready = 1'b1;
        do_reset();
        check("stats_ovf_cleared", 64'(ovf), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
